model_arbiter: RTL

MODEL_ARBITER -- requirements
Module: model_arbiter

---
 rtl/model_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/model_arbiter.sv
// model_arbiter: two-requester front end for a single shared fixed-latency
// model resource. One operation is in flight at a time:
// IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
// Build option: define MODEL_ARBITER_FIXED_PRIO_EN to replace the round-robin
// tie break with fixed priority (requester 0 always wins a tie).
module model_arbiter #(
    parameter int LATENCY = 2,   // res_start to res_o sample, 1..15
    parameter int WIDTH   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_i0,
    input  logic [WIDTH-1:0] req0_i1,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_o0,
    output logic [WIDTH-1:0] rsp0_o1,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_i0,
    input  logic [WIDTH-1:0] req1_i1,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_o0,
    output logic [WIDTH-1:0] rsp1_o1,
    // shared resource
    output logic             res_start,
    output logic [WIDTH-1:0] res_i0,
    output logic [WIDTH-1:0] res_i1,
    input  logic [WIDTH-1:0] res_o0,
    input  logic [WIDTH-1:0] res_o1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       owner_reg;     // requester that owns the in-flight operation
    logic [3:0] count_reg;     // cycles left before the resource result is sampled
    logic       grant;         // requester that would be accepted this IDLE cycle
    logic       accept;        // request handshake this cycle
    logic       sample;        // capture res_o into the owner's response registers

`ifdef MODEL_ARBITER_FIXED_PRIO_EN
    // Fixed priority: requester 1 is only chosen when requester 0 is idle.
    always_comb grant = ~req0_valid;
`else
    logic last_reg;            // requester granted most recently

    // Round-robin: on a tie, the requester not granted most recently wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_reg;
        end else begin
            grant = req1_valid;
        end
    end

    // Remember the latest grant; reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= grant;
        end
    end
`endif

    // Next-state logic and the state-decoded handshake / launch outputs.
    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        res_start  = 1'b0;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state_reg)
            IDLE: begin
                req0_ready = req0_valid & ~grant;
                req1_ready = req1_valid & grant;
                accept     = req0_ready | req1_ready;
                if (accept) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                res_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp0_valid = ~owner_reg;
                rsp1_valid = owner_reg;
                if ((!owner_reg && rsp0_ready) || (owner_reg && rsp1_ready)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand capture, latency counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            count_reg <= 4'd0;
            res_i0    <= '0;
            res_i1    <= '0;
            rsp0_o0   <= '0;
            rsp0_o1   <= '0;
            rsp1_o0   <= '0;
            rsp1_o1   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                res_i0    <= grant ? req1_i0 : req0_i0;
                res_i1    <= grant ? req1_i1 : req0_i1;
                owner_reg <= grant;
            end
            if (state_reg == LAUNCH) begin
                count_reg <= 4'(LATENCY - 1);
            end else if (state_reg == WAIT && count_reg != 4'd0) begin
                count_reg <= count_reg - 4'd1;
            end
            if (sample) begin
                if (owner_reg) begin
                    rsp1_o0 <= res_o0;
                    rsp1_o1 <= res_o1;
                end else begin
                    rsp0_o0 <= res_o0;
                    rsp0_o1 <= res_o1;
                end
            end
        end
    end

endmodule
